// File: rtl/multiplier_datapath_taint_track_bitwise_if.sv
// Strobe/operand bus between the multiplier control and its taint-tracking datapath.
interface multiplier_datapath_taint_track_bitwise_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0]   multiplicand, multiplicand_t, multiplier, multiplier_t;
  logic               rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t;
  logic               mrld, mrld_t, mdld, mdld_t;
  logic               productDone, productDone_t;
  logic [WIDTH-1:0]   multiplierReg, multiplierReg_t;
  logic [2*WIDTH-1:0] product, product_t;
  logic               productValid, productValid_t;

  modport master (
    output multiplicand, multiplicand_t, multiplier, multiplier_t,
    output rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t,
    output mrld, mrld_t, mdld, mdld_t, productDone, productDone_t,
    input  multiplierReg, multiplierReg_t, product, product_t,
    input  productValid, productValid_t
  );

  modport slave (
    input  multiplicand, multiplicand_t, multiplier, multiplier_t,
    input  rsload, rsload_t, rsclear, rsclear_t, rsshr, rsshr_t,
    input  mrld, mrld_t, mdld, mdld_t, productDone, productDone_t,
    output multiplierReg, multiplierReg_t, product, product_t,
    output productValid, productValid_t
  );
endinterface

// File: rtl/multiplier_datapath_taint_track_bitwise.sv
// Shift-add multiplier datapath with a per-bit taint shadow on md, mr and rs.
// Taint enters through data bits and through tainted control strobes.
module multiplier_datapath_taint_track_bitwise #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  multiplier_datapath_taint_track_bitwise_if.slave bus
);
  localparam int RW = 2*WIDTH + 1;

  logic [WIDTH-1:0] md, md_t, mr, mr_t;
  logic [RW-1:0]    rs, rs_t, rs_n, rs_t_n;
  logic             pv, pv_t;

  logic [WIDTH:0]   sum, sum_t;
  logic [WIDTH-1:0] pre;

  assign sum = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};

  // Conservative carry-chain taint: a sum bit is tainted once any operand
  // bit at or below it is tainted; the carry sees the whole chain.
  assign pre[0] = md_t[0] | rs_t[WIDTH];
  for (genvar j = 1; j < WIDTH; j++) begin : g_pre
    assign pre[j] = pre[j-1] | md_t[j] | rs_t[WIDTH+j];
  end
  assign sum_t = {pre[WIDTH-1], pre};

  always_comb begin
    rs_n   = rs;
    rs_t_n = rs_t;
    if (bus.rsclear) begin
      rs_n   = '0;
      rs_t_n = '0;
    end else if (bus.rsload) begin
      rs_n[2*WIDTH:WIDTH]   = sum;
      rs_t_n[2*WIDTH:WIDTH] = sum_t;
    end else if (bus.rsshr) begin
      rs_n   = {1'b0, rs[RW-1:1]};
      rs_t_n = {1'b0, rs_t[RW-1:1]};
    end
    if (bus.rsclear_t | bus.rsload_t | bus.rsshr_t) rs_t_n = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md   <= '0;
      md_t <= '0;
      mr   <= '0;
      mr_t <= '0;
      rs   <= '0;
      rs_t <= '0;
      pv   <= 1'b0;
      pv_t <= 1'b0;
    end else begin
      rs   <= rs_n;
      rs_t <= rs_t_n;
      if (bus.mdld) begin
        md   <= bus.multiplicand;
        md_t <= bus.multiplicand_t;
      end
      if (bus.mdld_t) md_t <= '1;
      if (bus.mrld) begin
        mr   <= bus.multiplier;
        mr_t <= bus.multiplier_t;
      end
      if (bus.mrld_t) mr_t <= '1;
      if (bus.rsclear)          pv <= 1'b0;
      else if (bus.productDone) pv <= 1'b1;
      // A tainted clear cannot be trusted to have scrubbed the valid taint.
      if (bus.rsclear && !bus.rsclear_t) pv_t <= 1'b0;
      else                               pv_t <= pv_t | bus.productDone_t;
    end
  end

  assign bus.multiplierReg   = mr;
  assign bus.multiplierReg_t = mr_t;
  assign bus.product         = rs[2*WIDTH-1:0];
  assign bus.product_t       = rs_t[2*WIDTH-1:0];
  assign bus.productValid    = pv;
  assign bus.productValid_t  = pv_t;
endmodule

// File: tb/tb_multiplier_datapath_taint_track_bitwise.sv
// Randomized scoreboard bench for the taint-tracking multiplier datapath.
module tb_multiplier_datapath_taint_track_bitwise;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiplier_datapath_taint_track_bitwise_if #(.WIDTH(W)) bus ();
  multiplier_datapath_taint_track_bitwise #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int mr, mr_t, prod, prod_t, pv_t;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int pvt_state = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic idle();
    bus.rsload = 0; bus.rsload_t = 0; bus.rsclear = 0; bus.rsclear_t = 0;
    bus.rsshr = 0; bus.rsshr_t = 0; bus.mrld = 0; bus.mrld_t = 0;
    bus.mdld = 0; bus.mdld_t = 0; bus.productDone = 0; bus.productDone_t = 0;
  endtask

  // Reference: product by multiplication; taint tracked as an integer bit
  // vector stepped through the control sequence, sum taint taken as all
  // bits from the lowest tainted operand position upward.
  function automatic exp_t model(input int md, mdt, mr, mrt, mdld_t, mrld_t,
                                 clr_t, inj, s, pd_t, pvt_prev);
    exp_t e;
    int rt, mdt_e, tv, j0, st;
    mdt_e = mdld_t ? 15 : mdt;
    rt = clr_t ? 'h1FF : 0;
    rt = rt >> 1;
    for (int i = 0; i < W; i++) begin
      if ((mr >> i) & 1) begin
        tv = mdt_e | ((rt >> W) & 15);
        if (tv != 0) begin
          j0 = 0;
          while (((tv >> j0) & 1) == 0) j0++;
          st = 'h1F & ~((1 << j0) - 1);
          rt = (rt & 15) | (st << W);
        end else rt = rt & 15;
      end
      if (inj == 1 && s == i) rt = 'h1FF;
      rt = rt >> 1;
      if (inj == 2 && s == i) rt = 'h1FF;
    end
    e.mr = mr;
    e.mr_t = mrld_t ? 15 : mrt;
    e.prod = md * mr;
    e.prod_t = rt & 'hFF;
    e.pv_t = (clr_t ? pvt_prev : 0) | pd_t;
    return e;
  endfunction

  task automatic run(input int md, mdt, mr, mrt, mdld_t, mrld_t, clr_t,
                     inj, s, pd_t, abort);
    exp_t e;
    if (!abort) begin
      e = model(md, mdt, mr, mrt, mdld_t, mrld_t, clr_t, inj, s, pd_t, pvt_state);
      pvt_state = e.pv_t;
      exp_q.push_back(e);
    end
    @(negedge clk); idle();
    bus.multiplicand = 4'(md); bus.multiplicand_t = 4'(mdt);
    bus.multiplier = 4'(mr); bus.multiplier_t = 4'(mrt);
    bus.mdld = 1; bus.mdld_t = 1'(mdld_t); bus.mrld = 1; bus.mrld_t = 1'(mrld_t);
    bus.rsclear = 1; bus.rsclear_t = 1'(clr_t);
    @(negedge clk); idle(); bus.rsshr = 1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk); idle();
      if (abort && i == 2) begin
        rst_n = 0;
        #1;
        chk("rst_mid_product", int'(bus.product), 0);
        chk("rst_mid_product_t", int'(bus.product_t), 0);
        chk("rst_mid_mreg", int'(bus.multiplierReg), 0);
        chk("rst_mid_mreg_t", int'(bus.multiplierReg_t), 0);
        chk("rst_mid_pv", int'(bus.productValid), 0);
        pvt_state = 0;
        @(negedge clk); rst_n = 1;
        return;
      end
      bus.rsload = 1'((mr >> i) & 1);
      bus.rsload_t = (inj == 1 && s == i);
      @(negedge clk); idle();
      bus.rsshr = 1; bus.rsshr_t = (inj == 2 && s == i);
      bus.productDone = (i == W-1); bus.productDone_t = (i == W-1) && pd_t != 0;
    end
    @(negedge clk); idle();
    @(negedge clk);
    chk("pv_held", int'(bus.productValid), 1);
  endtask

  // Monitor: pops one expectation on each rising edge of productValid.
  initial begin : monitor
    logic prev_pv;
    exp_t e;
    prev_pv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.productValid && !prev_pv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("product", int'(bus.product), e.prod);
          chk("product_t", int'(bus.product_t), e.prod_t);
          chk("mreg", int'(bus.multiplierReg), e.mr);
          chk("mreg_t", int'(bus.multiplierReg_t), e.mr_t);
          chk("pv_t", int'(bus.productValid_t), e.pv_t);
        end
      end
      prev_pv = bus.productValid;
    end
  end

  initial begin : stim
    int wait_cyc;
    idle();
    bus.multiplicand = 0; bus.multiplicand_t = 0;
    bus.multiplier = 0; bus.multiplier_t = 0;
    #12;
    chk("rst_product", int'(bus.product), 0);
    chk("rst_product_t", int'(bus.product_t), 0);
    chk("rst_mreg_t", int'(bus.multiplierReg_t), 0);
    chk("rst_pv", int'(bus.productValid), 0);
    chk("rst_pv_t", int'(bus.productValid_t), 0);
    @(negedge clk); rst_n = 1;

    run(3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    run(15, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);
    run(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run(3, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    run(9, 0, 6, 0, 0, 1, 0, 0, 0, 1, 0);
    run(7, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    run(7, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    run(11, 0, 13, 0, 0, 0, 0, 2, 3, 0, 0);
    run(6, 0, 15, 0, 1, 0, 0, 0, 0, 0, 0);
    run(3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    run(3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run($urandom_range(0, 15),
          ($urandom % 4 == 0) ? $urandom_range(0, 15) : 0,
          $urandom_range(0, 15), $urandom_range(0, 15),
          int'($urandom % 8 == 0), int'($urandom % 8 == 0),
          int'($urandom % 6 == 0), $urandom_range(0, 3), $urandom_range(0, 3),
          int'($urandom % 4 == 0), 0);
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
